// File: rtl/pixel_packet_assembler.sv
// Frames UART bytes into 24-bit pixel packets, validates header/footer/range and writes good pixels to image RAM.
// Latency: wr_en one clock after the byte2 strobe; no backpressure, every rx_valid byte is consumed or dropped.
module pixel_packet_assembler #(
  parameter int NUM_PIXELS     = 785,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int ERR_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [9:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic [31:0]      count_packets,
  output logic [ERR_W-1:0] err_count,
  output logic             receive_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GOT1, GOT2, DONE} state_t;

  state_t        state, state_nxt;
  logic [4:0]    loc_hi, loc_hi_nxt;
  logic [4:0]    loc_lo, loc_lo_nxt;
  logic [2:0]    data_hi, data_hi_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          wr_en_nxt;
  logic [9:0]    wr_addr_nxt;
  logic [7:0]    wr_data_nxt;
  logic [31:0]   count_nxt;
  logic          done_nxt;
  logic          err_inc;

  // Packet fields as seen while the third byte is on rx_data.
  logic [9:0] pkt_loc;
  logic [7:0] pkt_data;
  logic [2:0] pkt_footer;
  logic       pkt_ok;
  logic       tmo_hit;

  assign pkt_loc    = {loc_hi, loc_lo};
  assign pkt_data   = {data_hi, rx_data[7:3]};
  assign pkt_footer = {^pkt_data, ^pkt_loc, ^{pkt_data[7:4], pkt_loc[9:5]}};
  assign pkt_ok     = (pkt_footer == rx_data[2:0]) && (32'(pkt_loc) < NUM_PIXELS);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    loc_hi_nxt  = loc_hi;
    loc_lo_nxt  = loc_lo;
    data_hi_nxt = data_hi;
    tmo_nxt     = tmo_cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    count_nxt   = count_packets;
    done_nxt    = receive_done;
    err_inc     = 1'b0;
    case (state)
      IDLE: begin
        tmo_nxt = '0;
        if (rx_valid) begin
          if (rx_data[7:5] == 3'b101) begin
            loc_hi_nxt = rx_data[4:0];
            state_nxt  = GOT1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      GOT1: begin
        if (rx_valid) begin
          loc_lo_nxt  = rx_data[7:3];
          data_hi_nxt = rx_data[2:0];
          tmo_nxt     = '0;
          state_nxt   = GOT2;
        end else if (tmo_hit) begin
          err_inc   = 1'b1;
          tmo_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      GOT2: begin
        if (rx_valid) begin
          tmo_nxt   = '0;
          state_nxt = IDLE;
          if (pkt_ok) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = pkt_loc;
            wr_data_nxt = pkt_data;
            count_nxt   = count_packets + 32'd1;
            // Final pixel of the image: latch completion and stop accepting bytes.
            if (count_packets == 32'(NUM_PIXELS - 1)) begin
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end
          end else begin
            err_inc = 1'b1;
          end
        end else if (tmo_hit) begin
          err_inc   = 1'b1;
          tmo_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      loc_hi        <= '0;
      loc_lo        <= '0;
      data_hi       <= '0;
      tmo_cnt       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      count_packets <= '0;
      err_count     <= '0;
      receive_done  <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      loc_hi        <= '0;
      loc_lo        <= '0;
      data_hi       <= '0;
      tmo_cnt       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      count_packets <= '0;
      err_count     <= '0;
      receive_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      loc_hi        <= loc_hi_nxt;
      loc_lo        <= loc_lo_nxt;
      data_hi       <= data_hi_nxt;
      tmo_cnt       <= tmo_nxt;
      wr_en         <= wr_en_nxt;
      wr_addr       <= wr_addr_nxt;
      wr_data       <= wr_data_nxt;
      count_packets <= count_nxt;
      receive_done  <= done_nxt;
      if (err_inc && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_packet_assembler.sv
// Bench for pixel_packet_assembler: directed test-plan cases plus random packets scored against a packet-level model.
module tb_pixel_packet_assembler;

  localparam int NUM_PIXELS     = 785;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int ERR_W          = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             wr_en;
  logic [9:0]       wr_addr;
  logic [7:0]       wr_data;
  logic [31:0]      count_packets;
  logic [ERR_W-1:0] err_count;
  logic             receive_done;

  pixel_packet_assembler #(
    .NUM_PIXELS(NUM_PIXELS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count_packets(count_packets),
    .err_count(err_count), .receive_done(receive_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Packet-level reference model: bytes collected into a partial packet, expected writes queued.
  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         cnt;
    bit         done;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got;
  logic [7:0] part[$];
  int         m_idle = 0;
  int         m_count = 0;
  int         m_err = 0;
  bit         m_done = 1'b0;

  function automatic logic [2:0] footer_of(input logic [9:0] l, input logic [7:0] d);
    return {^d, ^l, ^{d[7:4], l[9:5]}};
  endfunction

  function void m_reset();
    part.delete();
    m_idle  = 0;
    m_count = 0;
    m_err   = 0;
    m_done  = 1'b0;
  endfunction

  function void m_err_inc();
    if (m_err < (1 << ERR_W) - 1) m_err++;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    logic [23:0] w;
    logic [9:0]  l;
    logic [7:0]  d;
    m_idle = 0;
    if (m_done) return;
    if (part.size() == 0 && b[7:5] != 3'b101) begin
      m_err_inc();
      return;
    end
    part.push_back(b);
    if (part.size() == 3) begin
      w = {part[0], part[1], part[2]};
      part.delete();
      l = w[20:11];
      d = w[10:3];
      if (w[2:0] == footer_of(l, d) && int'(l) < NUM_PIXELS) begin
        m_count++;
        m_done = (m_count == NUM_PIXELS);
        exp_q.push_back('{l, d, m_count, m_done});
      end else begin
        m_err_inc();
      end
    end
  endfunction

  function void m_idle_cycles(input int n);
    m_idle += n;
    if (part.size() > 0 && m_idle >= TIMEOUT_CYCLES) begin
      part.delete();
      m_err_inc();
    end
  endfunction

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        got = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(got.addr));
        chk("wr_data", 32'(wr_data), 32'(got.data));
        chk("count_at_write", count_packets, got.cnt);
        chk("done_at_write", 32'(receive_done), 32'(got.done));
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    m_idle_cycles(n);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    m_byte(b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (gap > 0) idle(gap);
  endtask

  task automatic send_pkt(input logic [9:0] l, input logic [7:0] d, input bit bad, input int gap);
    logic [23:0] w;
    logic [2:0]  f;
    f = footer_of(l, d);
    if (bad) f = f ^ 3'($urandom_range(1, 7));
    w = {3'b101, l, d, f};
    send(w[23:16], gap);
    send(w[15:8], gap);
    send(w[7:0], gap);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_reset();
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, count_packets, m_count);
    chk({tag, "_err"}, 32'(err_count), m_err);
    chk({tag, "_done"}, 32'(receive_done), 32'(m_done));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_count"}, count_packets, 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_done"}, 32'(receive_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gb;
    // Reset state
    #23;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();

    // Good packet with exact latency
    send(8'hA0, 0);
    send(8'h02, 0);
    send(8'hD0, 0);
    chk("good_wr_en_latency", 32'(wr_en), 1);
    chk("good_addr", 32'(wr_addr), 0);
    chk("good_data", 32'(wr_data), 32'h5A);
    idle(1);
    chk("good_wr_en_single", 32'(wr_en), 0);
    chk("good_addr_hold", 32'(wr_addr), 0);
    chk("good_data_hold", 32'(wr_data), 32'h5A);
    idle(2);
    chk("good_count", count_packets, 1);
    chk("good_err", 32'(err_count), 0);

    // Bad footer then recovery
    do_clear();
    send(8'hA0, 1); send(8'h02, 1); send(8'hD1, 3);
    chk("badftr_err", 32'(err_count), 1);
    chk("badftr_count", count_packets, 0);
    send(8'hA0, 0); send(8'h02, 0); send(8'hD0, 3);
    chk("badftr_recover_count", count_packets, 1);
    check_model("badftr");

    // Range check: loc 784 accepted, loc 785 rejected
    do_clear();
    send(8'hB8, 0); send(8'h87, 0); send(8'hFA, 0);
    chk("range_addr", 32'(wr_addr), 784);
    chk("range_data", 32'(wr_data), 32'hFF);
    send(8'hB8, 0); send(8'h88, 0); send(8'h00, 3);
    chk("range_count", count_packets, 1);
    chk("range_err", 32'(err_count), 1);

    // Resync on bad header
    do_clear();
    send(8'h12, 0);
    send(8'hA0, 0); send(8'h02, 0); send(8'hD0, 3);
    chk("resync_err", 32'(err_count), 1);
    chk("resync_count", count_packets, 1);

    // Timeout fires after TIMEOUT_CYCLES idle clocks
    do_clear();
    send(8'hA0, TIMEOUT_CYCLES);
    send(8'hA0, 0); send(8'h02, 0); send(8'hD0, 3);
    chk("tmo_err", 32'(err_count), 1);
    chk("tmo_count", count_packets, 1);
    chk("tmo_addr", 32'(wr_addr), 0);

    // One clock short of timeout: packet survives
    do_clear();
    send(8'hA0, TIMEOUT_CYCLES - 1);
    send(8'h02, TIMEOUT_CYCLES - 1);
    send(8'hD0, 3);
    chk("tmo_edge_err", 32'(err_count), 0);
    chk("tmo_edge_count", count_packets, 1);

    // Randomized packets, bad footers, out-of-range locs and garbage bytes
    do_clear();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        gb = 8'($urandom);
        if (gb[7:5] == 3'b101) gb[7:5] = 3'b011;
        send(gb, $urandom_range(0, 3));
      end
      send_pkt(10'($urandom_range(0, 820)), 8'($urandom), ($urandom_range(0, 4) == 0),
               $urandom_range(0, 3));
    end
    idle(3);
    check_model("random");

    // Asynchronous reset after byte1 of a packet
    send(8'hA0, 1);
    send(8'h02, 1);
    #2;
    rst = 1'b0;
    #3;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
    exp_q.delete();
    send(8'hA0, 0); send(8'h02, 0); send(8'hD0, 3);
    chk("midrst_count", count_packets, 1);
    check_model("midrst");

    // Clear wins over a concurrent byte
    send_pkt(10'd5, 8'h33, 1'b0, 0);
    idle(2);
    clear    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA0;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    rx_valid = 1'b0;
    m_reset();
    check_zero("clr_byte");
    send(8'h02, 0); send(8'hD0, 3);
    chk("clr_byte_err", 32'(err_count), 2);
    send(8'hA0, 0); send(8'h02, 0); send(8'hD0, 3);
    check_model("clr_after");

    // Full image, then extra packet ignored
    do_clear();
    for (int l = 0; l < NUM_PIXELS; l++)
      send_pkt(10'(l), 8'($urandom), 1'b0, 0);
    idle(3);
    chk("full_done", 32'(receive_done), 1);
    chk("full_count", count_packets, NUM_PIXELS);
    send(8'hA0, 0); send(8'h02, 0); send(8'hD0, 3);
    chk("full_extra_count", count_packets, NUM_PIXELS);
    chk("full_extra_done", 32'(receive_done), 1);
    check_model("full");
    do_clear();
    chk("full_clear_done", 32'(receive_done), 0);

    idle(3);
    chk("expected_writes_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_packet_assembler.md
Name: pixel_packet_assembler

Overview:
- Sits directly downstream of the UART receiver and upstream of the image RAM and CPU handshake.
- Frames the received byte stream into 24-bit pixel packets of the form {hdr[2:0]=3'b101, loc[9:0], data[7:0], footer[2:0]}, sent MSB-byte first.
- Checks header, footer and address range, then issues a one-cycle write of each good pixel to image RAM.
- Counts accepted packets and asserts receive_done once a full image has arrived.

Parameters:
- NUM_PIXELS, 785: pixels per image; valid loc range is 0..NUM_PIXELS-1.
- TIMEOUT_CYCLES, 2000: idle clocks allowed between bytes of one packet before the partial packet is discarded.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; restarts image reception.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  10  pixel location.
- wr_data  out  8  pixel value.
- count_packets  out  32  accepted packets since reset/clear.
- err_count  out  ERR_W  rejected bytes/packets, saturating.
- receive_done  out  1  sticky; full image received.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; wr_en=0; wr_addr=0; wr_data=0; count_packets=0; err_count=0; receive_done=0; timeout counter=0.
- clear: same effect as reset, applied synchronously. clear has priority over a concurrent rx_valid; that byte is dropped and not counted.
- Byte mapping:
  - byte0 = {3'b101, loc[9:5]}
  - byte1 = {loc[4:0], data[7:5]}
  - byte2 = {data[4:0], footer[2:0]}
- Required footer:
  - f[2] = ^data
  - f[1] = ^loc
  - f[0] = ^{data[7:4], loc[9:5]}
- States: IDLE, GOT1, GOT2, DONE.
- IDLE:
  - rx_valid with rx_data[7:5]==3'b101: latch loc[9:5], go to GOT1.
  - rx_valid with any other header: discard the byte, err_count+1, stay in IDLE. This is the resync mechanism.
- GOT1: on rx_valid, latch loc[4:0] and data[7:5], go to GOT2.
- GOT2: on rx_valid, latch data[4:0] and footer, evaluate the packet, return to IDLE.
- Packet evaluation, registered with 1-cycle latency (wr_en asserts on the clock edge after the byte2 rx_valid cycle):
  - Footer match and loc < NUM_PIXELS: wr_en=1 for exactly one cycle with wr_addr=loc and wr_data=data; count_packets+1 on the same edge.
  - Footer mismatch or loc >= NUM_PIXELS: no write, err_count+1.
- Timeout:
  - In GOT1/GOT2 the counter increments on each clock without rx_valid and resets on rx_valid.
  - On reaching TIMEOUT_CYCLES: discard the partial packet, err_count+1, go to IDLE.
  - A byte arriving on the same edge as expiry is processed normally; the timeout does not fire.
- Completion:
  - When count_packets reaches NUM_PIXELS, receive_done rises on the same edge as the final wr_en and the state goes to DONE.
  - DONE ignores all rx_valid and holds the counts and receive_done until clear or reset.
- Duplicate loc values are written again and counted again; no dedup.
- err_count saturates at all-ones. count_packets cannot exceed NUM_PIXELS.
- Outputs wr_addr and wr_data hold their last values when wr_en=0.

Test Plan:
- Good packet: bytes A0,02,D0 -> one wr_en pulse one cycle after the third strobe, wr_addr=0, wr_data=0x5A; count_packets=1; err_count=0.
- Bad footer: bytes A0,02,D1 -> no wr_en; err_count=1; next good packet A0,02,D0 is accepted normally.
- Range check: bytes B8,87,FA -> write of addr 784, data 0xFF. Bytes B8,88,00 (loc 785) -> no write; err_count+1.
- Resync and timeout:
  - Byte 0x12 then A0,02,D0 -> err_count=1, one write.
  - Byte A0, then TIMEOUT_CYCLES idle clocks, then A0,02,D0 -> err_count=1, one write at addr 0.
- Full image: 785 valid packets (loc 0..784) -> 785 wr_en pulses; receive_done=1 on the final-write edge; count_packets=785; a further packet produces no write.
- Reset/clear mid-operation:
  - rst low after byte1 of a packet -> all outputs return to reset values; next full packet accepted.
  - clear asserted in the same cycle as rx_valid -> the byte is dropped and counters are 0.
